// File: rtl/frame_lmfc_sysref_gen.sv
// Frame / LMFC phase generator for the JESD204B link layer.
// Programmable frame period and multiframe length, with Subclass-1 SYSREF
// alignment (programmable delay, one-shot or continuous acceptance).
module frame_lmfc_sysref_gen #(
  parameter int F_W   = 4,
  parameter int K_W   = 5,
  parameter int DLY_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [F_W-1:0]   i_F_m1,
  input  logic [K_W-1:0]   i_K_m1,
  input  logic             i_sysref,
  input  logic [1:0]       i_sysref_mode,
  input  logic [DLY_W-1:0] i_sysref_dly,
  input  logic             i_arm,
  output logic [F_W-1:0]   o_clk_cnt,
  output logic [K_W-1:0]   o_frame_cnt,
  output logic             o_frame_tick,
  output logic             o_lmfc_tick,
  output logic             o_aligned,
  output logic             o_realign
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [DLY_W-1:0] dly_cnt, dly_nxt;
  logic             sysref_q, armed;
  logic             sr_edge, m_one, m_cont, align_now, disarm;
  logic             clk_wrap;
  logic [F_W-1:0]   clk_free;
  logic [K_W-1:0]   frame_free;

  // Next free-running phase; >= makes a shrunk period wrap on the next cycle.
  always_comb begin
    clk_wrap   = (o_clk_cnt >= i_F_m1);
    clk_free   = clk_wrap ? '0 : o_clk_cnt + 1'b1;
    frame_free = o_frame_cnt;
    if (clk_wrap)
      frame_free = (o_frame_cnt >= i_K_m1) ? '0 : o_frame_cnt + 1'b1;
  end

  assign sr_edge = i_sysref & ~sysref_q;
  assign m_one   = (i_sysref_mode == 2'd1);
  assign m_cont  = (i_sysref_mode == 2'd2);

  // Ticks decode the current phase; held low while in reset.
  assign o_frame_tick = ~rst & (o_clk_cnt == '0);
  assign o_lmfc_tick  = ~rst & (o_clk_cnt == '0) & (o_frame_cnt == '0);

  // Delay FSM: decides in which cycle the counters get forced to zero.
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    align_now = 1'b0;
    disarm    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sr_edge && (m_cont || (m_one && armed))) begin
          disarm = m_one;
          if (i_sysref_dly == '0) begin
            align_now = 1'b1;
          end else begin
            dly_nxt   = i_sysref_dly - 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!m_one && !m_cont) begin
          // Ignore mode drops any pending alignment.
          state_nxt = ST_IDLE;
          dly_nxt   = '0;
        end else if (m_cont && sr_edge) begin
          // Continuous mode: a fresh edge restarts the delay.
          if (i_sysref_dly == '0) begin
            align_now = 1'b1;
            state_nxt = ST_IDLE;
            dly_nxt   = '0;
          end else begin
            dly_nxt = i_sysref_dly - 1'b1;
          end
        end else if (dly_cnt == '0) begin
          align_now = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          dly_nxt = dly_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        dly_nxt   = '0;
      end
    endcase
  end

  // FSM state, delay counter and SYSREF edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dly_cnt  <= '0;
      sysref_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      dly_cnt  <= dly_nxt;
      sysref_q <= i_sysref;
    end
  end

  // Phase counters: free-run, or snap to zero on an alignment decision.
  always_ff @(posedge clk) begin
    if (rst || align_now) begin
      o_clk_cnt   <= '0;
      o_frame_cnt <= '0;
    end else begin
      o_clk_cnt   <= clk_free;
      o_frame_cnt <= frame_free;
    end
  end

  // Arm/aligned status; an alignment outranks a coincident arm pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b1;
      o_aligned <= 1'b0;
      o_realign <= 1'b0;
    end else begin
      if (disarm)     armed <= 1'b0;
      else if (i_arm) armed <= 1'b1;
      if (align_now)  o_aligned <= 1'b1;
      else if (i_arm) o_aligned <= 1'b0;
      o_realign <= align_now && ((clk_free != '0) || (frame_free != '0));
    end
  end

endmodule

// File: tb/tb_frame_lmfc_sysref_gen.sv
// Directed bench for frame_lmfc_sysref_gen: free-run, period change,
// one-shot / continuous SYSREF, delay restart, reset mid-wait, re-arm.
module tb_frame_lmfc_sysref_gen;
  localparam int F_W = 4, K_W = 5, DLY_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [F_W-1:0]   i_F_m1 = 4'd1;
  logic [K_W-1:0]   i_K_m1 = 5'd3;
  logic             i_sysref = 1'b0;
  logic [1:0]       i_sysref_mode = 2'd0;
  logic [DLY_W-1:0] i_sysref_dly = '0;
  logic             i_arm = 1'b0;
  logic [F_W-1:0]   o_clk_cnt;
  logic [K_W-1:0]   o_frame_cnt;
  logic             o_frame_tick, o_lmfc_tick, o_aligned, o_realign;

  int checks = 0, failures = 0;
  int base, ec, ef, eal, era;

  always #5 clk = ~clk;

  frame_lmfc_sysref_gen #(.F_W(F_W), .K_W(K_W), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst(rst), .i_F_m1(i_F_m1), .i_K_m1(i_K_m1),
    .i_sysref(i_sysref), .i_sysref_mode(i_sysref_mode),
    .i_sysref_dly(i_sysref_dly), .i_arm(i_arm),
    .o_clk_cnt(o_clk_cnt), .o_frame_cnt(o_frame_cnt),
    .o_frame_tick(o_frame_tick), .o_lmfc_tick(o_lmfc_tick),
    .o_aligned(o_aligned), .o_realign(o_realign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Sample mid-cycle and check the full output set; ticks follow the phase.
  task automatic chk_cyc(input string tag, input int c, input int f, input int al, input int ra);
    @(negedge clk);
    chk({tag, "_clk"},   o_clk_cnt, c);
    chk({tag, "_frm"},   o_frame_cnt, f);
    chk({tag, "_ftick"}, o_frame_tick, (c == 0) ? 1 : 0);
    chk({tag, "_ltick"}, o_lmfc_tick, (c == 0 && f == 0) ? 1 : 0);
    chk({tag, "_alg"},   o_aligned, al);
    chk({tag, "_rea"},   o_realign, ra);
  endtask

  // Two reset edges, reset values checked; returns in the first free cycle.
  task automatic do_reset();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_clk", o_clk_cnt, 0);
    chk("rst_frm", o_frame_cnt, 0);
    chk("rst_ftick", o_frame_tick, 0);
    chk("rst_ltick", o_lmfc_tick, 0);
    chk("rst_alg", o_aligned, 0);
    chk("rst_rea", o_realign, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Free run F=2, K=4, ignore mode (a stray SYSREF must do nothing).
    do_reset();
    for (int i = 0; i < 16; i++) begin
      i_sysref = (i == 3);
      chk_cyc("free", i % 2, (i / 2) % 4, 0, 0);
      step();
    end
    i_sysref = 1'b0;

    // F=1 device clock, K=32, then shrink K while frame index is 20.
    i_F_m1 = 4'd0;
    i_K_m1 = 5'd31;
    for (int j = 0; j < 52; j++) begin
      chk_cyc("k32", 0, j % 32, 0, 0);
      step();
    end
    i_K_m1 = 5'd3;
    chk_cyc("kshrink", 0, 20, 0, 0);
    step();
    for (int k = 0; k < 8; k++) begin
      chk_cyc("k4", 0, k % 4, 0, 0);
      step();
    end

    // One-shot, delay 5: edge at clk=1/frame=2, second edge ignored.
    i_F_m1 = 4'd1;
    i_K_m1 = 5'd3;
    i_sysref_mode = 2'd1;
    i_sysref_dly = 4'd5;
    do_reset();
    for (int i = 0; i <= 22; i++) begin
      i_sysref = (i == 5 || i == 14);
      base = (i >= 11) ? 11 : 0;
      ec = (i - base) % 2;
      ef = ((i - base) / 2) % 4;
      chk_cyc("oneshot", ec, ef, (i >= 11) ? 1 : 0, (i == 11) ? 1 : 0);
      step();
    end
    i_sysref = 1'b0;

    // Continuous: periodic, skewed, restart in wait, reset in wait,
    // then one-shot with re-arm.
    i_sysref_mode = 2'd2;
    i_sysref_dly = 4'd0;
    do_reset();
    for (int i = 0; i <= 68; i++) begin
      i_sysref = (i == 3 || i == 11 || i == 19 || i == 28 || i == 35 ||
                  i == 37 || i == 48 || i == 57 || i == 60 || i == 64);
      i_arm = (i == 62);
      rst = (i == 50 || i == 51);
      if (i == 32) i_sysref_dly = 4'd4;
      if (i == 54) begin
        i_sysref_mode = 2'd1;
        i_sysref_dly = 4'd0;
      end
      if (i < 4)       base = 0;
      else if (i < 29) base = 4;
      else if (i < 42) base = 29;
      else if (i < 52) base = 42;
      else if (i < 58) base = 52;
      else if (i < 65) base = 58;
      else             base = 65;
      ec = (i - base) % 2;
      ef = ((i - base) / 2) % 4;
      eal = ((i >= 4 && i <= 49) || (i >= 58 && i <= 62) || i >= 65) ? 1 : 0;
      era = (i == 4 || i == 29 || i == 42 || i == 58 || i == 65) ? 1 : 0;
      if (i == 50) begin
        @(negedge clk);
        chk("rstwait_ftick", o_frame_tick, 0);
        chk("rstwait_ltick", o_lmfc_tick, 0);
      end else if (i == 51) begin
        @(negedge clk);
        chk("rstwait_clk", o_clk_cnt, 0);
        chk("rstwait_frm", o_frame_cnt, 0);
        chk("rstwait_ftick2", o_frame_tick, 0);
        chk("rstwait_ltick2", o_lmfc_tick, 0);
        chk("rstwait_alg", o_aligned, 0);
        chk("rstwait_rea", o_realign, 0);
      end else begin
        chk_cyc("cont", ec, ef, eal, era);
      end
      step();
    end
    i_sysref = 1'b0;
    i_arm = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_lmfc_sysref_gen.md
# frame_lmfc_sysref_gen

Programmable frame/LMFC timing generator for the JESD204B link layer. It generalises the fixed frame clock to a programmable frame period in device-clock cycles and a programmable multiframe length. It also adds Subclass-1 SYSREF alignment with a programmable delay and one-shot/continuous modes. It sits in the control path and drives frame and LMFC phase to the TX/RX link state machines and the ILAS/elastic-buffer logic.

## Interface
Parameters:
- F_W, 4, width of frame-period field; frame period is 1..2^F_W device clocks.
- K_W, 5, width of frames-per-multiframe field; K is 1..2^K_W.
- DLY_W, 4, width of SYSREF-to-LMFC alignment delay field.

Ports:
- clk  in  1  device clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_F_m1  in  F_W  device clocks per frame minus 1.
- i_K_m1  in  K_W  frames per multiframe minus 1.
- i_sysref  in  1  SYSREF, already synchronous to clk.
- i_sysref_mode  in  2  0 = ignore, 1 = one-shot, 2 = continuous, 3 = reserved (treated as 0).
- i_sysref_dly  in  DLY_W  cycles added between SYSREF edge and alignment.
- i_arm  in  1  single-cycle pulse; re-arms one-shot mode and clears o_aligned.
- o_clk_cnt  out  F_W  device-clock index within the current frame.
- o_frame_cnt  out  K_W  frame index within the current multiframe.
- o_frame_tick  out  1  high in the first cycle of every frame.
- o_lmfc_tick  out  1  high in the first cycle of every multiframe.
- o_aligned  out  1  a SYSREF alignment has occurred since the last reset or arm.
- o_realign  out  1  one-cycle pulse: an alignment moved the LMFC phase.

## Operation
- Counters:
  - o_clk_cnt increments every cycle and wraps to 0 when `>= i_F_m1`.
  - o_frame_cnt increments on each o_clk_cnt wrap and wraps to 0 when `>= i_K_m1`.
  - The `>=` compare ensures that shrinking i_F_m1 or i_K_m1 mid-run wraps on the next cycle and never runs away.
- LMFC period is (i_F_m1+1)*(i_K_m1+1) clocks. i_F_m1=0 gives frame clock = device clock, with period i_K_m1+1.
- Tick decode:
  - o_frame_tick = (o_clk_cnt==0).
  - o_lmfc_tick = (o_clk_cnt==0 && o_frame_cnt==0).
  - Both ticks are forced low while rst is high.
- Edge detect: sysref_q is registered. An edge occurs in cycle N when i_sysref=1 and sysref_q=0. Level-high SYSREF produces one edge only.
- Edge acceptance:
  - Mode 1: accepted only while armed. The block is armed after reset and after i_arm; acceptance disarms it.
  - Mode 2: every edge is accepted.
  - Mode 0/3: edges are ignored and any pending delay is cancelled.
- Delay state machine, states IDLE and WAIT:
  - Accepted edge with i_sysref_dly=0: align directly.
  - Accepted edge with i_sysref_dly>0: load dly_cnt = i_sysref_dly - 1, then go to WAIT.
  - WAIT: decrement dly_cnt each cycle; at 0, align and return to IDLE.
  - Mode 2, new accepted edge during WAIT: reload the delay (restart).
  - Mode 1, edge during WAIT: ignored.
- Align: both counters load 0 at the end of the align decision cycle, so cycle A = N+1+i_sysref_dly shows o_clk_cnt=0, o_frame_cnt=0, and both ticks high.
- o_aligned is set in cycle A and holds until rst or i_arm.
- o_realign is high in cycle A only if the free-running counters would not both have been 0 in A. An in-phase SYSREF gives no pulse.
- i_arm and an accepted edge in the same cycle: the edge wins, and o_aligned is set at A. i_arm during WAIT does not cancel the pending alignment.

## Timing
- Reset values: o_clk_cnt=0, o_frame_cnt=0, o_frame_tick=0, o_lmfc_tick=0, o_aligned=0, o_realign=0. Also dly_cnt=0, state IDLE, sysref_q=0, armed=1.
- First cycle after rst deasserts: counters are 0 and both ticks are high.
- Alignment latency: 1 + i_sysref_dly cycles from the edge cycle to the first aligned tick.
- rst during WAIT cancels the alignment. rst has priority over every other input.
- Config inputs are sampled every cycle and take effect at the next compare. No shadow registers.

## Test plan
- Free-run with i_F_m1=1, i_K_m1=3, mode 0 → o_frame_tick every 2 cycles, o_lmfc_tick every 8, o_frame_cnt sequence 0,0,1,1,2,2,3,3.
- i_F_m1=0, i_K_m1=31 → o_lmfc_tick period 32. Then change i_K_m1 to 3 while o_frame_cnt=20 → wrap next cycle, then period 4.
- Mode 1, i_sysref_dly=5, SYSREF edge at o_clk_cnt=1, o_frame_cnt=2 → zeros and both ticks 6 cycles later, o_realign pulse, o_aligned=1. A second edge → no change.
- Mode 2, periodic SYSREF every 8 cycles with i_F_m1=1, i_K_m1=3, dly=0 → first edge realigns (o_realign=1), later edges give o_realign=0. Then skew SYSREF by 1 cycle → o_realign pulse.
- Mode 2, second edge during WAIT → delay restarts, single alignment at the second edge + 1 + dly.
- rst asserted mid-WAIT → no alignment, all outputs at reset values. i_arm after alignment in mode 1 → o_aligned=0 and the next edge is accepted.
